// File: rtl/line_steer_ctrl.sv
// Line-sensor front end: per-channel synchronizer and debouncer feeding a
// steering FSM that enforces a minimum dwell between non-STOP directions.
module line_steer_ctrl #(
  parameter int unsigned NUM_SENSORS     = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 12_500_000,
  parameter int unsigned MIN_DWELL       = 2_500_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_SENSORS-1:0] sensor_raw,
  output logic [NUM_SENSORS-1:0] sensor_stable,
  output logic [3:0]             dir,
  output logic                   dir_change
);

  localparam int unsigned HALF = NUM_SENSORS / 2;
  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DW   = $clog2(MIN_DWELL + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(MIN_DWELL - 1);

  typedef enum logic [3:0] {
    FWD    = 4'b0000,
    VEER_L = 4'b0101,
    VEER_R = 4'b1001,
    STOP   = 4'b1111
  } state_t;

  logic [NUM_SENSORS-1:0] sync1;
  logic [NUM_SENSORS-1:0] sync2;
  logic [NUM_SENSORS-1:0] det;
  logic [CW-1:0]          cnt [NUM_SENSORS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
    end
  end

  assign det = ACTIVE_LOW ? ~sync2 : sync2;

  // A single agreeing cycle restarts the count, so only an uninterrupted
  // run of DEBOUNCE_CYCLES disagreeing cycles flips the stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensor_stable <= '0;
      for (int unsigned i = 0; i < NUM_SENSORS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        if (det[i] == sensor_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          sensor_stable[i] <= det[i];
          cnt[i]           <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  logic   left_seen;
  logic   right_seen;
  state_t state;
  state_t next;
  state_t target;
  logic [DW-1:0] dwell;

  assign left_seen  = |sensor_stable[NUM_SENSORS-1:HALF];
  assign right_seen = |sensor_stable[HALF-1:0];

  always_comb begin
    target = FWD;
    if (!en || (left_seen && right_seen)) target = STOP;
    else if (left_seen)                   target = VEER_R;
    else if (right_seen)                  target = VEER_L;

    next = state;
    if (target == STOP)               next = STOP;
    else if (state == STOP)           next = target;
    else if (dwell >= DWELL_LAST)     next = target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STOP;
      dwell      <= '0;
      dir_change <= 1'b0;
    end else begin
      state      <= next;
      dir_change <= (next != state);
      if (next != state)           dwell <= '0;
      else if (dwell < DWELL_LAST) dwell <= dwell + DW'(1);
    end
  end

  assign dir = state;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Directed bench for line_steer_ctrl with short debounce/dwell constants;
// all expected values are hand-derived cycle counts.
module tb_line_steer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] sensor_raw;
  logic [3:0] sensor_stable;
  logic [3:0] dir;
  logic       dir_change;

  int unsigned total = 0;
  int unsigned bad   = 0;

  line_steer_ctrl #(
    .NUM_SENSORS    (4),
    .ACTIVE_LOW     (1'b1),
    .DEBOUNCE_CYCLES(8),
    .MIN_DWELL      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sensor_raw   (sensor_raw),
    .sensor_stable(sensor_stable),
    .dir          (dir),
    .dir_change   (dir_change)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] st, input logic [3:0] d,
                            input logic chg);
    check_eq({tag, ".stable"}, {4'h0, sensor_stable}, {4'h0, st});
    check_eq({tag, ".dir"},    {4'h0, dir},           {4'h0, d});
    check_eq({tag, ".chg"},    {7'h0, dir_change},    {7'h0, chg});
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    sensor_raw = 4'hF;
    tick(2);
    expect_out("reset", 4'h0, 4'hF, 1'b0);

    // Leave STOP on the first edge after release.
    en    = 1'b1;
    rst_n = 1'b1;
    #1;
    expect_out("post_rel", 4'h0, 4'hF, 1'b0);
    tick(1);
    expect_out("to_fwd", 4'h0, 4'h0, 1'b1);
    tick(1);
    expect_out("fwd_hold", 4'h0, 4'h0, 1'b0);

    // 5-cycle glitch on raw[3] must never reach sensor_stable.
    sensor_raw = 4'b0111;
    tick(5);
    sensor_raw = 4'hF;
    for (int unsigned k = 0; k < 12; k++) begin
      tick(1);
      expect_out("glitch", 4'h0, 4'h0, 1'b0);
    end

    // Held left detection: stable at edge 10, VEER_R at edge 11.
    sensor_raw = 4'b0111;
    tick(9);
    expect_out("deb9", 4'h0, 4'h0, 1'b0);
    tick(1);
    expect_out("deb10", 4'h8, 4'h0, 1'b0);
    tick(1);
    expect_out("veer_r", 4'h8, 4'h9, 1'b1);
    tick(1);
    expect_out("veer_r_hold", 4'h8, 4'h9, 1'b0);

    // Release with dwell already saturated: FWD right after stable drops.
    sensor_raw = 4'hF;
    tick(9);
    expect_out("rel9", 4'h8, 4'h9, 1'b0);
    tick(1);
    expect_out("rel10", 4'h0, 4'h9, 1'b0);
    tick(1);
    expect_out("back_fwd", 4'h0, 4'h0, 1'b1);

    // Right detection -> VEER_L.
    sensor_raw = 4'b1110;
    tick(10);
    expect_out("r_deb", 4'h1, 4'h0, 1'b0);
    tick(1);
    expect_out("veer_l", 4'h1, 4'h5, 1'b1);

    // Add left detection: both sides -> STOP on the next edge.
    sensor_raw = 4'b0110;
    tick(10);
    expect_out("both_deb", 4'h9, 4'h5, 1'b0);
    tick(1);
    expect_out("stop_both", 4'h9, 4'hF, 1'b1);

    // Release raw[0], then raw[3] two cycles later: target FWD appears at dwell 1.
    sensor_raw = 4'b0111;
    tick(2);
    sensor_raw = 4'hF;
    tick(8);
    expect_out("dw_e10", 4'h8, 4'hF, 1'b0);
    tick(1);
    expect_out("dw_e11", 4'h8, 4'h9, 1'b1);
    tick(1);
    expect_out("dw_e12", 4'h0, 4'h9, 1'b0);
    tick(1);
    expect_out("dw_e13", 4'h0, 4'h9, 1'b0);
    tick(1);
    expect_out("dw_e14", 4'h0, 4'h9, 1'b0);
    tick(1);
    expect_out("dw_e15", 4'h0, 4'h0, 1'b1);

    // en drop inside the dwell window forces STOP at once; re-enable leaves immediately.
    en = 1'b0;
    tick(1);
    expect_out("en_off", 4'h0, 4'hF, 1'b1);
    en = 1'b1;
    tick(1);
    expect_out("en_on", 4'h0, 4'h0, 1'b1);

    // Asynchronous reset with raw[3]'s counter at 5.
    sensor_raw = 4'b0111;
    tick(7);
    expect_out("pre_rst", 4'h0, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 4'h0, 4'hF, 1'b0);
    #1 rst_n = 1'b1;
    // Cleared synchronizers read as detection, so raw[3] counts from edge 1 and flips at edge 8.
    tick(1);
    expect_out("rr_e1", 4'h0, 4'h0, 1'b1);
    tick(6);
    expect_out("rr_e7", 4'h0, 4'h0, 1'b0);
    tick(1);
    expect_out("rr_e8", 4'h8, 4'h0, 1'b0);
    tick(1);
    expect_out("rr_e9", 4'h8, 4'h9, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
